// File: rtl/pipe_add_pkg.sv
// Shared definitions for the pipelined-adder family: state encoding and default sizes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pipe_add_pkg;

    // Default adder geometry, shared with the pipe_adder benches
    localparam int DEF_WIDTH = 16;
    localparam int DEF_LAT   = 4;

    // Accumulator FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/pipe_sum_accumulator_delay.sv
// Valid delay line: re-times the adder issue strobe so it lines up with the adder's output.
// Latency: exactly DEPTH cycles from i_vld to o_vld.
// Backpressure: none; the chain shifts every cycle and is cleared by reset.
module valid_delay_line #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_vld,
    output logic o_vld
);

    logic [DEPTH-1:0] r_shift;

    // Shift the strobe one stage per cycle; the shift form also covers DEPTH == 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
        end else begin
            r_shift <= (r_shift << 1) | DEPTH'(i_vld);
        end
    end

    assign o_vld = r_shift[DEPTH-1];

endmodule

// File: rtl/pipe_sum_accumulator.sv
// Accumulates {cout,sum} from the pipelined adder over a programmed run length.
// Latency: result valid one cycle after the final aligned sample (LAT+1 after its issue).
// Backpressure: result held in DONE until out_rdy; samples arriving outside ACCUM are dropped.
// Optional feature macro: PIPE_ACC_SATURATE_EN (saturating accumulate plus sticky sat_flag).
module pipe_sum_accumulator
    import pipe_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = DEF_LAT,
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_vld,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [ACC_W-1:0] acc_out,
    output logic             drop_err
`ifdef PIPE_ACC_SATURATE_EN
    ,
    output logic             sat_flag
`endif
);

    acc_state_t       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;
    logic             r_out_vld;
    logic             r_busy;
    logic             r_drop_err;

    logic             w_avld;
    logic [ACC_W-1:0] w_sample;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

`ifdef PIPE_ACC_SATURATE_EN
    logic             r_sat;
    logic [ACC_W:0]   w_add_full;
    logic             w_ovf;
`endif

    // Aligned valid: the adder has no strobe of its own, so re-time issue_vld here
    valid_delay_line #(
        .DEPTH (LAT)
    ) u_dly (
        .clk   (clk),
        .rst   (rst),
        .i_vld (issue_vld),
        .o_vld (w_avld)
    );

    // Carry-extended sample, zero-padded to accumulator width
    assign w_sample  = ACC_W'({cout, sum});
    assign w_cnt_nxt = r_cnt + CNT_W'(1);

`ifdef PIPE_ACC_SATURATE_EN
    // Saturating add: an extra top bit flags overflow and clamps to all-ones
    always_comb begin
        w_add_full = {1'b0, r_acc} + {1'b0, w_sample};
        w_ovf      = w_add_full[ACC_W];
        w_acc_nxt  = w_ovf ? {ACC_W{1'b1}} : w_add_full[ACC_W-1:0];
    end
`else
    // Wrap-around add modulo 2**ACC_W
    always_comb begin
        w_acc_nxt = r_acc + w_sample;
    end
`endif

    // Run-control FSM with counter, accumulator and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_len      <= '0;
            r_out_vld  <= 1'b0;
            r_busy     <= 1'b0;
            r_drop_err <= 1'b0;
`ifdef PIPE_ACC_SATURATE_EN
            r_sat      <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // No run open: any aligned sample has nowhere to go
                    if (w_avld) begin
                        r_drop_err <= 1'b1;
                    end
                    // A zero-length run would never complete, so it is not accepted
                    if (start && (len != '0)) begin
                        r_state <= ST_ACCUM;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_len   <= len;
                        r_busy  <= 1'b1;
`ifdef PIPE_ACC_SATURATE_EN
                        r_sat   <= 1'b0;
`endif
                    end
                end
                ST_ACCUM: begin
                    if (w_avld) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= w_cnt_nxt;
`ifdef PIPE_ACC_SATURATE_EN
                        if (w_ovf) begin
                            r_sat <= 1'b1;
                        end
`endif
                        if (w_cnt_nxt == r_len) begin
                            r_state   <= ST_DONE;
                            r_out_vld <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Result is held; late samples are dropped but do not stall the handshake
                    if (w_avld) begin
                        r_drop_err <= 1'b1;
                    end
                    if (out_rdy) begin
                        r_state   <= ST_IDLE;
                        r_out_vld <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_out_vld <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign out_vld  = r_out_vld;
    assign acc_out  = r_acc;
    assign drop_err = r_drop_err;
`ifdef PIPE_ACC_SATURATE_EN
    assign sat_flag = r_sat;
`endif

endmodule

// File: tb/tb_pipe_sum_accumulator.sv
// Bench for pipe_sum_accumulator: two instances (ACC_W=24 and ACC_W=17) share one stimulus
// stream; a run-level model predicts every output each cycle, and directed literals pin it.
module tb_pipe_sum_accumulator;

    localparam int LAT = 4;
    localparam int AWA = 24;
    localparam int AWB = 17;

    logic        clk;
    logic        rst;
    logic        issue_vld;
    logic [16:0] op;
    logic [15:0] sum;
    logic        cout;
    logic        start;
    logic [7:0]  len;
    logic        out_rdy;

    logic            busy_a, out_vld_a, drop_a;
    logic [AWA-1:0]  acc_a;
    logic            busy_b, out_vld_b, drop_b;
    logic [AWB-1:0]  acc_b;
`ifdef PIPE_ACC_SATURATE_EN
    logic            sat_a, sat_b;
`endif

    int checks = 0;
    int errors = 0;

    pipe_sum_accumulator #(.WIDTH(16), .LAT(LAT), .ACC_W(AWA), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .issue_vld(issue_vld), .sum(sum), .cout(cout),
        .start(start), .len(len), .busy(busy_a), .out_vld(out_vld_a), .out_rdy(out_rdy),
        .acc_out(acc_a), .drop_err(drop_a)
`ifdef PIPE_ACC_SATURATE_EN
        , .sat_flag(sat_a)
`endif
    );

    pipe_sum_accumulator #(.WIDTH(16), .LAT(LAT), .ACC_W(AWB), .CNT_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .issue_vld(issue_vld), .sum(sum), .cout(cout),
        .start(start), .len(len), .busy(busy_b), .out_vld(out_vld_b), .out_rdy(out_rdy),
        .acc_out(acc_b), .drop_err(drop_b)
`ifdef PIPE_ACC_SATURATE_EN
        , .sat_flag(sat_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external adder: the operand issued now appears LAT cycles later
    logic [16:0] apipe [LAT];
    initial for (int i = 0; i < LAT; i++) apipe[i] = '0;
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) apipe[i] <= apipe[i-1];
        apipe[0] <= op;
    end
    assign {cout, sum} = apipe[LAT-1];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int aw(input int k);
        return (k == 0) ? AWA : AWB;
    endfunction

    function automatic longint amax(input int k);
        return (longint'(1) << aw(k)) - 1;
    endfunction

    // Run-level model: 0 = no run, 1 = collecting, 2 = result pending
    int     m_st = 0;
    int     m_len = 0;
    int     m_cnt = 0;
    longint m_tot [2] = '{0, 0};
    bit     m_sat [2] = '{0, 0};
    bit     m_drop = 0;
    int     ecyc = 0;
    int          due_q [$];
    logic [16:0] val_q [$];

    always @(posedge clk) begin : model
        bit          al;
        logic [16:0] v;
        ecyc++;
        al = 1'b0;
        v  = '0;
        if (rst) begin
            m_st = 0; m_len = 0; m_cnt = 0; m_drop = 0;
            m_tot[0] = 0; m_tot[1] = 0; m_sat[0] = 0; m_sat[1] = 0;
            due_q.delete(); val_q.delete();
        end else begin
            if (due_q.size() != 0 && due_q[0] == ecyc) begin
                al = 1'b1;
                v  = val_q.pop_front();
                void'(due_q.pop_front());
            end
            if (issue_vld) begin
                due_q.push_back(ecyc + LAT);
                val_q.push_back(op);
            end
            case (m_st)
                0: begin
                    if (al) m_drop = 1;
                    if (start && len != 0) begin
                        m_st = 1; m_len = int'(len); m_cnt = 0;
                        m_tot[0] = 0; m_tot[1] = 0; m_sat[0] = 0; m_sat[1] = 0;
                    end
                end
                1: begin
                    if (al) begin
                        for (int k = 0; k < 2; k++) begin
                            m_tot[k] = m_tot[k] + longint'(v);
`ifdef PIPE_ACC_SATURATE_EN
                            if (m_tot[k] > amax(k)) begin
                                m_tot[k] = amax(k);
                                m_sat[k] = 1;
                            end
`else
                            m_tot[k] = m_tot[k] % (amax(k) + 1);
`endif
                        end
                        m_cnt++;
                        if (m_cnt == m_len) m_st = 2;
                    end
                end
                default: begin
                    if (al) m_drop = 1;
                    if (out_rdy) m_st = 0;
                end
            endcase
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy_a", busy_a, 0);   chk("rst_vld_a", out_vld_a, 0);
            chk("rst_acc_a", acc_a, 0);     chk("rst_drop_a", drop_a, 0);
            chk("rst_busy_b", busy_b, 0);   chk("rst_vld_b", out_vld_b, 0);
            chk("rst_acc_b", acc_b, 0);     chk("rst_drop_b", drop_b, 0);
        end else begin
            chk("busy_a", busy_a, m_st != 0);  chk("out_vld_a", out_vld_a, m_st == 2);
            chk("acc_a", acc_a, m_tot[0]);     chk("drop_a", drop_a, m_drop);
            chk("busy_b", busy_b, m_st != 0);  chk("out_vld_b", out_vld_b, m_st == 2);
            chk("acc_b", acc_b, m_tot[1]);     chk("drop_b", drop_b, m_drop);
`ifdef PIPE_ACC_SATURATE_EN
            chk("sat_a", sat_a, m_sat[0]);     chk("sat_b", sat_b, m_sat[1]);
`endif
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [16:0] val);
        issue_vld = 1'b1;
        op        = val;
        tick();
        issue_vld = 1'b0;
    endtask

    task automatic begin_run(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_out(input int max_cyc);
        for (int i = 0; i < max_cyc && !out_vld_a; i++) tick();
        chk("out_vld_within_budget", out_vld_a, 1);
    endtask

    task automatic accept;
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk("vld_drop_after_accept", out_vld_a, 0);
        chk("idle_after_accept", busy_a, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin : stim
        rst = 1'b1; issue_vld = 1'b0; op = '0; start = 1'b0; len = '0; out_rdy = 1'b0;
        repeat (3) tick();
        chk("reset_busy", busy_a, 0);
        chk("reset_out_vld", out_vld_a, 0);
        chk("reset_acc", acc_a, 0);
        chk("reset_drop", drop_a, 0);
        rst = 1'b0;
        tick();

        // Reset mid-run with two samples in flight: no result, no drop flagged
        begin_run(8'd3);
        issue(17'h00001);
        issue(17'h00002);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("no_out_after_rst", out_vld_a, 0);
        end
        chk("drop_clear_after_rst", drop_a, 0);

        // Plain three-sample run
        begin_run(8'd3);
        issue(17'h00001);
        issue(17'h00002);
        issue(17'h00003);
        wait_out(20);
        chk("sum_1_2_3", acc_a, 24'h000006);
        accept();

        // Carry contributes bit WIDTH
        begin_run(8'd2);
        issue(17'h1FFFF);
        issue(17'h1FFFF);
        wait_out(20);
        chk("carry_sum", acc_a, 24'h03FFFE);
        accept();

        // Latency: result exactly LAT+1 cycles after the issue cycle
        begin_run(8'd1);
        issue_vld = 1'b1; op = 17'h00005;
        tick();
        issue_vld = 1'b0;
        repeat (LAT - 1) tick();
        chk("avld_at_lat", u_dut_a.w_avld, 1);
        chk("no_out_at_lat", out_vld_a, 0);
        tick();
        chk("out_at_lat_plus_1", out_vld_a, 1);
        chk("latency_acc", acc_a, 24'h000005);
        accept();

        // Backpressure: hold for 5 cycles, late sample is dropped
        begin_run(8'd1);
        issue(17'h00ABC);
        wait_out(20);
        for (int i = 0; i < 5; i++) begin
            issue_vld = (i == 0);
            op        = 17'h00007;
            chk("held_vld", out_vld_a, 1);
            chk("held_acc", acc_a, 24'h000ABC);
            tick();
        end
        issue_vld = 1'b0;
        chk("drop_in_done", drop_a, 1);
        chk("acc_unchanged_by_drop", acc_a, 24'h000ABC);
        accept();

        // Sample arriving in the same DONE cycle as out_rdy: dropped, handshake completes
        rst = 1'b1; tick(); rst = 1'b0; tick();
        chk("drop_cleared_by_rst", drop_a, 0);
        begin_run(8'd1);
        issue(17'h00010);
        wait_out(20);
        issue(17'h00020);
        repeat (LAT - 1) tick();
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk("coincident_handshake", out_vld_a, 0);
        chk("coincident_drop", drop_a, 1);
        chk("coincident_acc", acc_a, 24'h000010);

        // Illegal control: zero length ignored, start during a run ignored
        begin_run(8'd0);
        chk("len0_ignored", busy_a, 0);
        tick();
        chk("len0_still_idle", busy_a, 0);
        begin_run(8'd2);
        begin_run(8'd5);
        issue(17'h00100);
        issue(17'h00200);
        wait_out(20);
        chk("restart_ignored_acc", acc_a, 24'h000300);
        accept();

        // Overflow on the 17-bit instance
        begin_run(8'd3);
        issue(17'h1FFFF);
        issue(17'h1FFFF);
        issue(17'h1FFFF);
        wait_out(20);
        chk("ovf_wide_acc", acc_a, 24'h05FFFD);
`ifdef PIPE_ACC_SATURATE_EN
        chk("ovf_narrow_sat_acc", acc_b, 17'h1FFFF);
        chk("ovf_narrow_sat_flag", sat_b, 1);
        chk("ovf_wide_no_sat", sat_a, 0);
`else
        chk("ovf_narrow_wrap_acc", acc_b, 17'h1FFFD);
`endif
        accept();
`ifdef PIPE_ACC_SATURATE_EN
        begin_run(8'd1);
        chk("sat_cleared_on_start", sat_b, 0);
        issue(17'h00001);
        wait_out(20);
        accept();
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
